// File: rtl/opti_sos_scheduler.sv
// opti_sos_scheduler: time-multiplexes one shared biquad datapath across NUM_SOS cascaded sections
module opti_sos_scheduler #(
  parameter int NUM_SOS     = 4,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample_data,
  output logic              o_sample_ready,
  output logic              o_sec_issue,
  output logic              o_sec_clr,
  output logic [2:0]        o_sec_idx,
  output logic [DATA_W-1:0] o_sec_x,
  input  logic              i_sec_result_valid,
  input  logic [DATA_W-1:0] i_sec_result,
  output logic              o_y_valid,
  output logic [DATA_W-1:0] o_y_data,
  output logic              o_busy,
  output logic              o_err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SAMPLE, ISSUE, WAIT_RESULT} state_t;
  state_t          r_state;
  logic [2:0]      r_k;
  logic [CW-1:0]   r_cnt;
  logic            r_stop;
  logic            w_last, w_stop, w_spur, w_drop;
  assign w_last = r_k == 3'(NUM_SOS - 1);
  assign w_stop = r_stop | i_stop;
  assign w_spur = i_sec_result_valid && r_state != WAIT_RESULT;
  assign w_drop = i_sample_valid && !o_sample_ready && r_state != IDLE;
  // o_sec_x doubles as the operand register carried from section to section
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_k            <= '0;
      r_cnt          <= '0;
      r_stop         <= 1'b0;
      o_sample_ready <= 1'b0;
      o_sec_issue    <= 1'b0;
      o_sec_clr      <= 1'b0;
      o_sec_idx      <= '0;
      o_sec_x        <= '0;
      o_y_valid      <= 1'b0;
      o_y_data       <= '0;
      o_busy         <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      o_sec_issue <= 1'b0;
      o_sec_clr   <= 1'b0;
      o_y_valid   <= 1'b0;
      o_err       <= o_err | w_spur | w_drop;
      if (r_state != IDLE && i_stop) r_stop <= 1'b1;
      case (r_state)
        IDLE: if (i_start) begin
          o_err     <= w_spur;
          r_k       <= '0;
          o_sec_clr <= 1'b1;
          o_sec_idx <= '0;
          o_busy    <= 1'b1;
          r_state   <= CLEAR;
        end
        CLEAR: if (w_last) begin
          r_k            <= '0;
          o_busy         <= 1'b0;
          o_sample_ready <= 1'b1;
          r_state        <= WAIT_SAMPLE;
        end else begin
          r_k       <= r_k + 3'd1;
          o_sec_clr <= 1'b1;
          o_sec_idx <= r_k + 3'd1;
        end
        WAIT_SAMPLE: if (w_stop) begin
          o_sample_ready <= 1'b0;
          r_stop         <= 1'b0;
          r_state        <= IDLE;
        end else if (i_sample_valid) begin
          o_sample_ready <= 1'b0;
          o_busy         <= 1'b1;
          r_k            <= '0;
          o_sec_x        <= i_sample_data;
          o_sec_idx      <= '0;
          o_sec_issue    <= 1'b1;
          r_cnt          <= '0;
          r_state        <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= WAIT_RESULT;
        end
        WAIT_RESULT: if (i_sec_result_valid) begin
          if (w_last) begin
            o_y_data       <= i_sec_result;
            o_y_valid      <= 1'b1;
            o_busy         <= 1'b0;
            r_k            <= '0;
            o_sample_ready <= !w_stop;
            r_stop         <= 1'b0;
            r_state        <= w_stop ? IDLE : WAIT_SAMPLE;
          end else begin
            r_k         <= r_k + 3'd1;
            o_sec_idx   <= r_k + 3'd1;
            o_sec_x     <= i_sec_result;
            o_sec_issue <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ISSUE;
          end
        end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          o_err   <= 1'b1;
          o_busy  <= 1'b0;
          r_k     <= '0;
          r_stop  <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_opti_sos_scheduler.sv
// tb_opti_sos_scheduler: directed bench with a +1-per-section datapath model and output scoreboard
module tb_opti_sos_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_ready, sec_issue, sec_clr, y_valid, busy, err;
  logic [2:0]  sec_idx;
  logic [15:0] sec_x, y_data, sec_result, dp_res = '0;
  logic        sec_result_valid, dp_valid = 1'b0, spur_valid = 1'b0, mute = 1'b0;
  logic [15:0] dp_val = '0;
  int          dp_cnt = 0;
  int          n_tests = 0, n_fail = 0, cyc = 0;
  logic [15:0] sb[$];

  assign sec_result_valid = dp_valid | spur_valid;
  assign sec_result       = spur_valid ? 16'h5555 : dp_res;

  opti_sos_scheduler #(.NUM_SOS(4), .DATA_W(16), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_sample_valid(sample_valid), .i_sample_data(sample_data),
    .o_sample_ready(sample_ready), .o_sec_issue(sec_issue), .o_sec_clr(sec_clr),
    .o_sec_idx(sec_idx), .o_sec_x(sec_x), .i_sec_result_valid(sec_result_valid),
    .i_sec_result(sec_result), .o_y_valid(y_valid), .o_y_data(y_data),
    .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // datapath model: answers x+1 three cycles after each issue unless section 2 is muted
  always @(negedge clk) begin
    dp_valid = 1'b0;
    if (!rst_n) dp_cnt = 0;
    else begin
      if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0) begin
          dp_valid = 1'b1;
          dp_res   = dp_val + 16'd1;
        end
      end
      if (sec_issue && !(mute && sec_idx == 3'd2)) begin
        dp_cnt = 3;
        dp_val = sec_x;
      end
    end
  end

  always @(negedge clk) if (rst_n && y_valid) begin
    if (sb.size() == 0) chk("y_unexpected", {31'b0, y_valid}, 32'd0);
    else chk("y_data", {16'b0, y_data}, {16'b0, sb.pop_front()});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!sample_ready && n < 60) begin tick(); n++; end
    chk(tag, {31'b0, sample_ready}, 32'd1);
  endtask

  task automatic accept(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic check_clear(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_clr"}, {31'b0, sec_clr}, 32'd1);
      chk({tag, "_idx"}, {29'b0, sec_idx}, i);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      tick();
    end
    chk({tag, "_ready"}, {31'b0, sample_ready}, 32'd1);
    chk({tag, "_clr_off"}, {31'b0, sec_clr}, 32'd0);
  endtask

  initial begin
    int t_prev;
    int n;
    logic [15:0] d;
    tick(); tick();
    chk("rst_ready", {31'b0, sample_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_yv", {31'b0, y_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    // clear sequence
    do_start();
    check_clear("clear");
    // single sample through four sections
    sb.push_back(16'h0104);
    accept(16'h0100);
    for (int s = 0; s < 4; s++) begin
      chk("single_issue", {31'b0, sec_issue}, 32'd1);
      chk("single_x", {16'b0, sec_x}, 32'h0100 + s);
      chk("single_idx", {29'b0, sec_idx}, s);
      repeat (4) tick();
    end
    chk("single_yv", {31'b0, y_valid}, 32'd1);
    chk("single_ready", {31'b0, sample_ready}, 32'd1);
    // back-to-back samples, one accept per 17 cycles
    t_prev = 0;
    for (int i = 0; i < 10; i++) begin
      wait_ready("b2b_ready");
      if (i > 0) chk("b2b_interval", cyc - t_prev, 32'd17);
      t_prev = cyc;
      d = 16'h0A00 + 16'(i * 16'h0111);
      sb.push_back(d + 16'd4);
      accept(d);
    end
    wait_ready("b2b_last");
    chk("b2b_err", {31'b0, err}, 32'd0);
    // stop mid-sample: the sample completes, then IDLE
    sb.push_back(16'h0304);
    accept(16'h0300);
    tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    n = 0;
    while (!y_valid && n < 40) begin tick(); n++; end
    chk("stop_yv", {31'b0, y_valid}, 32'd1);
    chk("stop_ready_at_y", {31'b0, sample_ready}, 32'd0);
    tick();
    chk("stop_idle_busy", {31'b0, busy}, 32'd0);
    sample_valid = 1'b1;
    repeat (3) tick();
    sample_valid = 1'b0;
    chk("idle_ready", {31'b0, sample_ready}, 32'd0);
    chk("idle_valid_noerr", {31'b0, err}, 32'd0);
    // spurious result in WAIT_SAMPLE
    do_start();
    wait_ready("spur_ready");
    spur_valid = 1'b1; tick(); spur_valid = 1'b0;
    chk("spur_err", {31'b0, err}, 32'd1);
    tick();
    chk("spur_err_sticky", {31'b0, err}, 32'd1);
    // start outside IDLE is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ign_err", {31'b0, err}, 32'd1);
    chk("start_ign_clr", {31'b0, sec_clr}, 32'd0);
    chk("start_ign_ready", {31'b0, sample_ready}, 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_ws_ready", {31'b0, sample_ready}, 32'd0);
    do_start();
    chk("start_clears_err", {31'b0, err}, 32'd0);
    // dropped sample: valid held while ready is low
    wait_ready("drop_ready");
    sb.push_back(16'h0404);
    sample_valid = 1'b1; sample_data = 16'h0400;
    tick(); tick();
    sample_valid = 1'b0;
    chk("drop_err", {31'b0, err}, 32'd1);
    wait_ready("drop_done");
    stop = 1'b1; tick(); stop = 1'b0;
    // timeout on section 2
    do_start();
    wait_ready("to_ready");
    mute = 1'b1;
    accept(16'h0500);
    n = 0;
    while (!(sec_issue && sec_idx == 3'd2) && n < 40) begin tick(); n++; end
    chk("to_issue2", {31'b0, sec_issue}, 32'd1);
    repeat (14) tick();
    chk("to_err_early", {31'b0, err}, 32'd0);
    tick();
    chk("to_err", {31'b0, err}, 32'd1);
    chk("to_busy", {31'b0, busy}, 32'd0);
    chk("to_ready_idle", {31'b0, sample_ready}, 32'd0);
    repeat (5) tick();
    mute = 1'b0;
    do_start();
    chk("to_start_clears", {31'b0, err}, 32'd0);
    wait_ready("to_restart");
    // async reset during WAIT_RESULT
    accept(16'h0600);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_x", {16'b0, sec_x}, 32'd0);
    chk("arst_y", {16'b0, y_data}, 32'd0);
    chk("arst_ready", {31'b0, sample_ready}, 32'd0);
    chk("arst_idx", {29'b0, sec_idx}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    check_clear("reclear");
    repeat (30) tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
